// File: rtl/serialmul_sched.sv
// serialmul_sched: round-robin front end for one shared serial shift-add multiplier.
// It grants one requester at a time, runs WIDTH multiply steps, then holds the tagged
// product until the consumer accepts it.
module serialmul_sched #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [2*WIDTH-1:0]     rsp_p,
    input  logic                   rsp_ready,
    output logic                   busy
);

    localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [ID_W-1:0] LastId  = ID_W'(N_REQ - 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [ID_W-1:0]    id_q;
    logic [ID_W-1:0]    last_q;
    logic [CntW-1:0]    cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic               rsp_valid_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic [2*WIDTH-1:0] rsp_p_q;
    logic               busy_q;

    logic               grant_any;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    cand;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic               accept;
    logic [2*WIDTH-1:0] partial;
    logic [2*WIDTH-1:0] acc_d;

    // Round-robin winner: first valid requester after last_q, wrapping around.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = last_q;
        for (int i = 0; i < int'(N_REQ); i++) begin
            cand = (cand == LastId) ? '0 : cand + 1'b1;
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // One-hot grant and operand mux; grant is suppressed outside IDLE and during reset.
    always_comb begin
        req_ready = '0;
        sel_a     = '0;
        sel_b     = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
                if (state_q == StIdle && !rst && grant_any) begin
                    req_ready[i] = 1'b1;
                end
            end
        end
        accept = |(req_valid & req_ready);
    end

    // One shift-add step: add a shifted by the current bit position when b's LSB is set.
    always_comb begin
        partial = b_q[0] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0;
        acc_d   = acc_q + partial;
    end

    // Scheduler FSM with registered response and busy outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            last_q      <= LastId;
            cnt_q       <= '0;
            acc_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_p_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        a_q     <= sel_a;
                        b_q     <= sel_b;
                        id_q    <= grant_idx;
                        last_q  <= grant_idx;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StMul;
                    end
                end
                StMul: begin
                    acc_q <= acc_d;
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        rsp_valid_q <= 1'b1;
                        rsp_p_q     <= acc_d;
                        rsp_id_q    <= id_q;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_p     = rsp_p_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_serialmul_sched.sv
// Directed bench for serialmul_sched: table of single requests plus hand-written
// sequences for arbitration order, backpressure, mid-operation reset and a full sweep.
module tb_serialmul_sched;

    localparam int N_REQ = 4;
    localparam int WIDTH = 4;
    localparam int ID_W  = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ-1:0]       req_ready;
    logic                   rsp_valid;
    logic [ID_W-1:0]        rsp_id;
    logic [2*WIDTH-1:0]     rsp_p;
    logic                   rsp_ready;
    logic                   busy;

    int errors = 0;
    int checks = 0;
    bit stall_en = 1'b0;

    serialmul_sched #(
        .N_REQ(N_REQ),
        .WIDTH(WIDTH),
        .ID_W (ID_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_id   (rsp_id),
        .rsp_p    (rsp_p),
        .rsp_ready(rsp_ready),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int a;
        int b;
        int p;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input int a, input int b);
        req_valid[id]             = 1'b1;
        req_a[id*WIDTH +: WIDTH]  = WIDTH'(a);
        req_b[id*WIDTH +: WIDTH]  = WIDTH'(b);
    endtask

    // Wait for the grant, check it is one-hot on exp_id, let it be accepted, then check
    // latency and the tagged product; stalls rsp_ready randomly when stall_en is set.
    task automatic serve(input int exp_id, input int exp_p);
        int cyc;
        int n;
        cyc = 0;
        #1;
        while (req_ready == '0 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("grant_onehot", int'(req_ready), 1 << exp_id);
        tick();
        req_valid[exp_id] = 1'b0;
        chk("busy_after_accept", int'(busy), 1);
        chk("ready_low_in_mul", int'(req_ready), 0);
        cyc = 0;
        while (!rsp_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("latency", cyc, WIDTH);
        chk("rsp_p", int'(rsp_p), exp_p);
        chk("rsp_id", int'(rsp_id), exp_id);
        n = stall_en ? int'($urandom_range(0, 3)) : 0;
        rsp_ready = 1'b0;
        for (int k = 0; k < n; k++) begin
            tick();
            chk("stall_valid", int'(rsp_valid), 1);
            chk("stall_p", int'(rsp_p), exp_p);
        end
        rsp_ready = 1'b1;
        tick();
        chk("rsp_released", int'(rsp_valid), 0);
    endtask

    initial begin
        vec_t vecs[6];
        int   busy_cnt;
        int   cyc;

        vecs[0] = '{id: 2, a: 13, b: 11, p: 143};
        vecs[1] = '{id: 0, a: 0,  b: 15, p: 0};
        vecs[2] = '{id: 3, a: 15, b: 15, p: 225};
        vecs[3] = '{id: 1, a: 7,  b: 9,  p: 63};
        vecs[4] = '{id: 2, a: 1,  b: 1,  p: 1};
        vecs[5] = '{id: 0, a: 12, b: 5,  p: 60};

        rst       = 1'b1;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        #2;
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_p", int'(rsp_p), 0);
        chk("rst_rsp_id", int'(rsp_id), 0);
        chk("rst_busy", int'(busy), 0);
        req_valid = '0;
        tick();
        rst = 1'b0;
        tick();

        // Single request with busy-duration measurement.
        set_req(2, 13, 11);
        #1;
        chk("single_ready", int'(req_ready), 4'b0100);
        chk("single_busy_idle", int'(busy), 0);
        tick();
        req_valid = '0;
        busy_cnt = 0;
        cyc = 0;
        while (busy && cyc < 20) begin
            busy_cnt++;
            tick();
            cyc++;
        end
        chk("single_busy_cycles", busy_cnt, 5);
        tick();

        // Table of single requests.
        foreach (vecs[i]) begin
            set_req(vecs[i].id, vecs[i].a, vecs[i].b);
            serve(vecs[i].id, vecs[i].p);
        end

        // All four valid right after reset: order 0,1,2,3.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N_REQ; i++) set_req(i, i + 1, 15);
        for (int i = 0; i < N_REQ; i++) serve(i, (i + 1) * 15);

        // Rotation: after 1, with 0,1,3 valid the order is 3,0,1.
        set_req(1, 2, 3);
        serve(1, 6);
        set_req(0, 3, 3);
        set_req(1, 4, 4);
        set_req(3, 5, 5);
        serve(3, 25);
        serve(0, 9);
        serve(1, 16);

        // Backpressure: hold DONE for 6 cycles while requester 0 waits.
        rsp_ready = 1'b0;
        set_req(2, 5, 6);
        #1;
        chk("bp_grant", int'(req_ready), 4'b0100);
        tick();
        req_valid = '0;
        set_req(0, 2, 7);
        cyc = 0;
        while (!rsp_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("bp_latency", cyc, WIDTH);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("bp_valid", int'(rsp_valid), 1);
            chk("bp_p", int'(rsp_p), 30);
            chk("bp_id", int'(rsp_id), 2);
            chk("bp_no_grant", int'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_idle_busy", int'(busy), 0);
        chk("bp_idle_valid", int'(rsp_valid), 0);
        serve(0, 14);

        // Reset during the second MUL cycle of 9x9 from requester 3.
        set_req(3, 9, 9);
        tick();
        set_req(0, 9, 9);
        tick();
        rst = 1'b1;
        #1;
        chk("mr_valid", int'(rsp_valid), 0);
        chk("mr_p", int'(rsp_p), 0);
        chk("mr_id", int'(rsp_id), 0);
        chk("mr_busy", int'(busy), 0);
        chk("mr_ready", int'(req_ready), 0);
        tick();
        rst = 1'b0;
        serve(0, 81);
        serve(3, 81);

        // Exhaustive sweep on requester 0 with random response stalls.
        stall_en = 1'b1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                set_req(0, a, b);
                serve(0, a * b);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/serialmul_sched.md
# serialmul_sched

Round-robin scheduler that lets up to N_REQ requesters share one unsigned WIDTH×WIDTH shift-add serial multiplier engine. It grants one request at a time, computes the product over WIDTH clock cycles, and returns the product tagged with the requester index. The response is held until it is accepted. It sits between the client blocks and the serial multiplier datapath, replacing direct per-client multiplier instances.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 4, operand width in bits; product width is 2*WIDTH
- ID_W, 2, width of requester index; must satisfy 2**ID_W >= N_REQ
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req_valid  input  N_REQ  per-requester request pending
- req_a  input  N_REQ*WIDTH  multiplicands; requester i uses bits [i*WIDTH +: WIDTH]
- req_b  input  N_REQ*WIDTH  multipliers, same packing as req_a
- req_ready  output  N_REQ  one-hot grant; a request is accepted on a cycle where req_valid[i] & req_ready[i]
- rsp_valid  output  1  product available
- rsp_id  output  ID_W  index of the requester that owns the product
- rsp_p  output  2*WIDTH  unsigned product a*b
- rsp_ready  input  1  consumer accepts the response
- busy  output  1  high in every state except IDLE

## Operation
- FSM states: IDLE, MUL, DONE.
- IDLE:
  - Choose the winner by scanning req_valid from index (last+1) mod N_REQ upward, with wrap-around.
  - req_ready is combinational: one-hot on the winner when any req_valid is high, otherwise all zero. It is never asserted outside IDLE.
  - On acceptance: latch a_reg, b_reg, id_reg; set last = winner; acc = 0; cnt = 0; go to MUL.
- MUL, one step per cycle:
  - If b_reg[0], acc += a_reg shifted left by cnt, computed at 2*WIDTH bits with no overflow possible.
  - b_reg shifts right by 1; cnt increments.
  - The step with cnt == WIDTH-1 is the last one; go to DONE.
  - Zero operands still take the full WIDTH cycles. There is no early termination.
- DONE:
  - rsp_valid = 1; rsp_p = acc; rsp_id = id_reg. All three are registered and stable while waiting.
  - When rsp_ready is high, go to IDLE at that edge.
  - No new request is accepted in the same cycle as the response handshake.
- Request inputs are sampled only at the acceptance edge. Later changes to req_a/req_b do not affect an operation in flight.
- Fairness: after requester k is granted, every other requester that is continuously valid is granted before k is granted again.

## Timing
- Reset (async, takes effect immediately) clears:
  - state = IDLE; req_ready = 0 (stays 0 while rst is high); rsp_valid = 0; rsp_id = 0; rsp_p = 0; busy = 0.
  - last = N_REQ-1, so requester 0 has first priority after reset.
- Latency: request accepted at edge E0 → rsp_valid high after edge E0+WIDTH (4 cycles at default WIDTH).
- Throughput: one product per WIDTH+2 cycles when rsp_ready is held high (acceptance cycle + WIDTH MUL cycles + DONE cycle).
- Backpressure: DONE is held indefinitely while rsp_ready = 0. All requests stay un-granted meanwhile.
- Reset in MUL or DONE aborts the operation. The result is discarded and never presented; the requester must re-request.
- A requester that drops req_valid before it is granted loses nothing. The grant moves to the next valid requester in the same cycle.
- req_valid[i] high with no acceptance (not in IDLE) has no effect.

## Test plan
- Single request: requester 2 with a=13, b=11, rsp_ready=1 → req_ready=4'b0100 for one cycle; rsp_valid after exactly 4 cycles with rsp_p=143, rsp_id=2; busy high for 5 cycles.
- Simultaneous requests right after reset: all four requesters valid and held → grant order 0,1,2,3, each product correct (e.g. a=i+1, b=15 → 15, 30, 45, 60).
- Rotation fairness: grant requester 1, then requesters 0, 1 and 3 valid → next grant is 3, then 0, then 1.
- Backpressure: rsp_ready low for 6 cycles in DONE → rsp_valid, rsp_p and rsp_id stay stable; no req_ready pulse; IDLE is entered on the edge after rsp_ready rises.
- Reset mid-operation: assert rst during the 2nd MUL cycle of 9×9 → all outputs 0 immediately; after release, requester 0 is granted first and a fresh 9×9 returns 81.
- Exhaustive sweep: requester 0 steps a,b over 0..15 (256 pairs) with random rsp_ready stalls → every rsp_p equals a*b. Checks include 0×15=0 taking the full latency and 15×15=225.
